// File: rtl/core_pkg.sv
// Shared core definitions used by the EX-stage multiply/divide unit.
//
// Contents:
//   OPCODE_R, FUNCT7_R_MULDIV     decoder encodings that select the unit
//   FUNCT3_MULDIV_*               operation encodings carried on funct3
//   muldiv_state_e                control states of muldiv_unit
//   funct3_a_signed/_b_signed     per-operation operand signedness
package core_pkg;

  localparam logic [6:0] OPCODE_R        = 7'b0110011;
  localparam logic [6:0] FUNCT7_R_MULDIV = 7'h01;

  localparam logic [2:0] FUNCT3_MULDIV_MUL    = 3'd0;
  localparam logic [2:0] FUNCT3_MULDIV_MULH   = 3'd1;
  localparam logic [2:0] FUNCT3_MULDIV_MULHSU = 3'd2;
  localparam logic [2:0] FUNCT3_MULDIV_MULHU  = 3'd3;
  localparam logic [2:0] FUNCT3_MULDIV_DIV    = 3'd4;
  localparam logic [2:0] FUNCT3_MULDIV_DIVU   = 3'd5;
  localparam logic [2:0] FUNCT3_MULDIV_REM    = 3'd6;
  localparam logic [2:0] FUNCT3_MULDIV_REMU   = 3'd7;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    DONE
  } muldiv_state_e;

  // Operand A is treated as signed for MULH, MULHSU, DIV and REM.
  function automatic logic funct3_a_signed(input logic [2:0] funct3);
    return (funct3 == FUNCT3_MULDIV_MULH)   || (funct3 == FUNCT3_MULDIV_MULHSU) ||
           (funct3 == FUNCT3_MULDIV_DIV)    || (funct3 == FUNCT3_MULDIV_REM);
  endfunction

  // Operand B is treated as signed for MULH, DIV and REM only.
  function automatic logic funct3_b_signed(input logic [2:0] funct3);
    return (funct3 == FUNCT3_MULDIV_MULH) || (funct3 == FUNCT3_MULDIV_DIV) ||
           (funct3 == FUNCT3_MULDIV_REM);
  endfunction

endpackage

// File: rtl/muldiv_divider.sv
// Unsigned restoring divider core, one quotient bit per clock.
//
// Ports:
//   clk, rst_n            clock and asynchronous active-low reset
//   start                 load dividend/divisor and begin (ignored during abort)
//   abort                 drop any division in progress
//   dividend, divisor     unsigned magnitudes
//   quotient, remainder   results, final while done is high
//   done                  one-cycle pulse DATA_WIDTH clocks after start
module muldiv_divider #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic [DATA_WIDTH-1:0] quotient,
  output logic [DATA_WIDTH-1:0] remainder,
  output logic                  done
);

  logic [DATA_WIDTH-1:0] quo;
  logic [DATA_WIDTH-1:0] rem;
  logic [DATA_WIDTH-1:0] dvs;
  logic [CNT_WIDTH-1:0]  cnt;
  logic                  active;
  logic [DATA_WIDTH:0]   shifted;
  logic [DATA_WIDTH:0]   diff;

  // The partial remainder always stays below the divisor, so the trial
  // difference fits in DATA_WIDTH bits and its top bit is a pure borrow.
  assign shifted = {rem, quo[DATA_WIDTH-1]};
  assign diff    = shifted - {1'b0, dvs};
  assign done    = active && (cnt == CNT_WIDTH'(DATA_WIDTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quo    <= '0;
      rem    <= '0;
      dvs    <= '0;
      cnt    <= '0;
      active <= 1'b0;
    end else if (abort) begin
      active <= 1'b0;
    end else if (start) begin
      quo    <= dividend;
      rem    <= '0;
      dvs    <= divisor;
      cnt    <= '0;
      active <= 1'b1;
    end else if (active) begin
      if (done) begin
        active <= 1'b0;
      end else begin
        if (!diff[DATA_WIDTH]) begin
          rem <= diff[DATA_WIDTH-1:0];
          quo <= {quo[DATA_WIDTH-2:0], 1'b1};
        end else begin
          rem <= shifted[DATA_WIDTH-1:0];
          quo <= {quo[DATA_WIDTH-2:0], 1'b0};
        end
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign quotient  = quo;
  assign remainder = rem;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage.
//
// Ports:
//   clk, rst_n              clock and asynchronous active-low reset
//   i_valid / o_ready       request handshake (accepted only in IDLE)
//   i_funct3                MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
//   i_rs1_data, i_rs2_data  operand A (dividend/multiplicand), operand B
//   i_flush                 abort whatever is in flight; beats valid and ready
//   o_valid / i_ready       result handshake, result held until accepted
//   o_result                result
//   o_busy                  high from accept until the result retires
//
// Build option MULDIV_FAST_MUL_EN: multiplies complete in one combinational
// step and the iterative MUL state is not built; division is unchanged.
module muldiv_unit
  import core_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [2:0]            i_funct3,
  input  logic [DATA_WIDTH-1:0] i_rs1_data,
  input  logic [DATA_WIDTH-1:0] i_rs2_data,
  input  logic                  i_flush,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_result,
  output logic                  o_busy
);

  localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  muldiv_state_e state, state_next;
  logic          accept;

  logic                  in_sign_a, in_sign_b;
  logic [DATA_WIDTH-1:0] in_abs_a, in_abs_b;
  logic                  is_div, div_zero, div_ovf, special;
  logic [DATA_WIDTH-1:0] special_result;

  logic                  sign_a, sign_b, short_op;
  logic [2:0]            op;
  logic [DATA_WIDTH-1:0] result;

  logic                  div_done;
  logic [DATA_WIDTH-1:0] quotient, remainder, div_result;

  assign is_div    = i_funct3[2];
  assign in_sign_a = funct3_a_signed(i_funct3) && i_rs1_data[DATA_WIDTH-1];
  assign in_sign_b = funct3_b_signed(i_funct3) && i_rs2_data[DATA_WIDTH-1];
  assign in_abs_a  = in_sign_a ? -i_rs1_data : i_rs1_data;
  assign in_abs_b  = in_sign_b ? -i_rs2_data : i_rs2_data;

  // Divide-by-zero and signed overflow have architecturally fixed answers,
  // so they are resolved at accept time and never reach the divider.
  // funct3[1] distinguishes REM/REMU from DIV/DIVU.
  assign div_zero = (i_rs2_data == '0);
  assign div_ovf  = ((i_funct3 == FUNCT3_MULDIV_DIV) || (i_funct3 == FUNCT3_MULDIV_REM)) &&
                    (i_rs1_data == MOST_NEG) && (i_rs2_data == '1);
  assign special  = is_div && (div_zero || div_ovf);
  assign special_result = div_zero ? (i_funct3[1] ? i_rs1_data : '1)
                                   : (i_funct3[1] ? '0 : i_rs1_data);

  muldiv_divider #(
    .DATA_WIDTH(DATA_WIDTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_divider (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (accept && is_div && !special),
    .abort    (i_flush),
    .dividend (in_abs_a),
    .divisor  (in_abs_b),
    .quotient (quotient),
    .remainder(remainder),
    .done     (div_done)
  );

  // Quotient is negative when the operand signs differ; remainder takes the
  // dividend's sign.
  assign div_result = op[1] ? (sign_a ? -remainder : remainder)
                            : ((sign_a ^ sign_b) ? -quotient : quotient);

`ifdef MULDIV_FAST_MUL_EN
  logic signed [DATA_WIDTH:0]     ext_a, ext_b;
  logic signed [2*DATA_WIDTH-1:0] fast_prod;
  logic [DATA_WIDTH-1:0]          fast_result;

  // One extra bit lets a single signed multiplier cover all four signedness
  // combinations.
  assign ext_a       = {funct3_a_signed(i_funct3) && i_rs1_data[DATA_WIDTH-1], i_rs1_data};
  assign ext_b       = {funct3_b_signed(i_funct3) && i_rs2_data[DATA_WIDTH-1], i_rs2_data};
  assign fast_prod   = ext_a * ext_b;
  assign fast_result = (i_funct3 == FUNCT3_MULDIV_MUL) ? fast_prod[DATA_WIDTH-1:0]
                                                       : fast_prod[2*DATA_WIDTH-1:DATA_WIDTH];
`else
  logic [DATA_WIDTH-1:0]   mcand;
  logic [2*DATA_WIDTH-1:0] acc;
  logic [CNT_WIDTH-1:0]    cnt;
  logic [DATA_WIDTH:0]     add_sum;
  logic [2*DATA_WIDTH-1:0] product;
  logic [DATA_WIDTH-1:0]   mul_result;
  logic                    mul_last;

  // acc holds {partial product, remaining multiplier bits}; each step adds
  // the multiplicand into the upper half when the current multiplier bit is
  // set and shifts the whole thing right, carry included.
  assign mul_last   = (cnt == CNT_WIDTH'(DATA_WIDTH));
  assign add_sum    = {1'b0, acc[2*DATA_WIDTH-1:DATA_WIDTH]} + {1'b0, (acc[0] ? mcand : '0)};
  assign product    = (sign_a ^ sign_b) ? -acc : acc;
  assign mul_result = (op == FUNCT3_MULDIV_MUL) ? product[DATA_WIDTH-1:0]
                                                : product[2*DATA_WIDTH-1:DATA_WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand <= '0;
      acc   <= '0;
      cnt   <= '0;
    end else if (accept) begin
      mcand <= in_abs_a;
      acc   <= {{DATA_WIDTH{1'b0}}, in_abs_b};
      cnt   <= '0;
    end else if ((state == MUL) && !mul_last) begin
      acc <= {add_sum, acc[DATA_WIDTH-1:1]};
      cnt <= cnt + 1'b1;
    end
  end
`endif

  // short_op marks requests whose answer is already in result at accept;
  // they spend a single cycle in DIV before presenting it in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      op       <= '0;
      short_op <= 1'b0;
      result   <= '0;
    end else if (accept) begin
      sign_a <= in_sign_a;
      sign_b <= in_sign_b;
      op     <= i_funct3;
`ifdef MULDIV_FAST_MUL_EN
      short_op <= special || !is_div;
      result   <= is_div ? special_result : fast_result;
`else
      short_op <= special;
      result   <= special_result;
`endif
    end else if ((state == DIV) && !short_op && div_done) begin
      result <= div_result;
    end
`ifndef MULDIV_FAST_MUL_EN
    else if ((state == MUL) && mul_last) begin
      result <= mul_result;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    o_ready    = 1'b0;
    o_valid    = 1'b0;
    o_busy     = 1'b1;
    case (state)
      IDLE: begin
        o_ready = 1'b1;
        o_busy  = 1'b0;
        if (i_valid && !i_flush) begin
          accept = 1'b1;
`ifdef MULDIV_FAST_MUL_EN
          state_next = DIV;
`else
          state_next = is_div ? DIV : MUL;
`endif
        end
      end
`ifndef MULDIV_FAST_MUL_EN
      MUL: begin
        if (mul_last) state_next = DONE;
      end
`endif
      DIV: begin
        if (short_op || div_done) state_next = DONE;
      end
      DONE: begin
        o_valid = 1'b1;
        if (i_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (i_flush) state_next = IDLE;
  end

  assign o_result = result;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: stimulus pushes expected results and
// latencies into a scoreboard, and an independent monitor compares them
// against whatever the unit presents on its result handshake.
module tb_muldiv_unit;

  localparam int W = 32;

  logic          clk;
  logic          rst_n;
  logic          i_valid;
  logic          o_ready;
  logic [2:0]    i_funct3;
  logic [W-1:0]  i_rs1_data;
  logic [W-1:0]  i_rs2_data;
  logic          i_flush;
  logic          o_valid;
  logic          i_ready;
  logic [W-1:0]  o_result;
  logic          o_busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit lat_seen = 1'b0;

  typedef struct {
    logic [31:0] result;
    int          issue;
    int          lat;
  } exp_t;

  exp_t scoreboard[$];

  muldiv_unit #(.DATA_WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .i_funct3  (i_funct3),
    .i_rs1_data(i_rs1_data),
    .i_rs2_data(i_rs2_data),
    .i_flush   (i_flush),
    .o_valid   (o_valid),
    .i_ready   (i_ready),
    .o_result  (o_result),
    .o_busy    (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference model straight from the RV32M definitions using 64-bit math.
  function automatic logic [31:0] refModel(input logic [2:0] f, input logic [31:0] a,
                                           input logic [31:0] b);
    longint      xa, xb, sp;
    logic [63:0] up;
    xa = longint'($signed(a));
    xb = longint'($signed(b));
    case (f)
      3'd0: begin sp = xa * xb; up = sp; return up[31:0]; end
      3'd1: begin sp = xa * xb; up = sp; return up[63:32]; end
      3'd2: begin sp = xa * longint'({32'd0, b}); up = sp; return up[63:32]; end
      3'd3: begin up = {32'd0, a} * {32'd0, b}; return up[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        sp = xa / xb; up = sp; return up[31:0];
      end
      3'd5: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        sp = xa % xb; up = sp; return up[31:0];
      end
      default: begin
        if (b == 32'd0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic int expLatency(input logic [2:0] f, input logic [31:0] a,
                                    input logic [31:0] b);
    if (f[2] && (b == 32'd0)) return 1;
    if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef MULDIV_FAST_MUL_EN
    if (!f[2]) return 1;
`endif
    return W + 1;
  endfunction

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom();
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic waitReady();
    int t = 0;
    while (!o_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!o_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL ready_timeout: got o_ready=0 expected o_ready=1 within 200 cycles");
    end
  endtask

  // Issue one operation, hold the result for 'stall' cycles, then accept it.
  task automatic applyStimulus(input logic [2:0] f, input logic [31:0] a,
                               input logic [31:0] b, input int stall);
    exp_t e;
    int   t;
    logic bad;
    waitReady();
    i_valid    = 1'b1;
    i_funct3   = f;
    i_rs1_data = a;
    i_rs2_data = b;
    i_ready    = 1'b0;
    e.result   = refModel(f, a, b);
    e.issue    = cyc + 1;
    e.lat      = expLatency(f, a, b);
    scoreboard.push_back(e);
    @(negedge clk);
    i_valid    = 1'b0;
    i_funct3   = 3'($urandom());
    i_rs1_data = $urandom();
    i_rs2_data = $urandom();
    t   = 0;
    bad = 1'b0;
    while (!o_valid && t < 200) begin
      if (o_ready || !o_busy) bad = 1'b1;
      @(negedge clk);
      t++;
    end
    if (!o_valid) begin
      checks++;
      errors++;
      $display("[TB] FAIL valid_timeout: got o_valid=0 expected o_valid=1 within 200 cycles");
      if (scoreboard.size() > 0) void'(scoreboard.pop_front());
    end else begin
      if (o_ready || !o_busy) bad = 1'b1;
      checkOutput("busy_while_pending", {31'd0, bad}, 32'd0);
      repeat (stall) @(negedge clk);
      i_ready = 1'b1;
      @(negedge clk);
      i_ready = 1'b0;
      checkOutput("idle_after_ack", {31'd0, o_ready}, 32'd1);
    end
  endtask

  // Monitor: compares every presented result against the scoreboard head.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (rst_n && o_valid) begin
        if (scoreboard.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_valid: got o_valid=1 result %0h expected no result",
                   o_result);
        end else begin
          if (!lat_seen) begin
            lat_seen = 1'b1;
            checkOutput("latency", 32'(cyc - scoreboard[0].issue), 32'(scoreboard[0].lat));
          end
          checkOutput("result", o_result, scoreboard[0].result);
          if (i_ready) begin
            void'(scoreboard.pop_front());
            lat_seen = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    logic [2:0] f;
    logic       saw_valid;

    rst_n      = 1'b0;
    i_valid    = 1'b0;
    i_funct3   = 3'd0;
    i_rs1_data = '0;
    i_rs2_data = '0;
    i_flush    = 1'b0;
    i_ready    = 1'b0;
    #12;
    checkOutput("reset_ready", {31'd0, o_ready}, 32'd1);
    checkOutput("reset_valid", {31'd0, o_valid}, 32'd0);
    checkOutput("reset_busy", {31'd0, o_busy}, 32'd0);
    checkOutput("reset_result", o_result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    applyStimulus(3'd0, 32'd7, 32'hFFFF_FFFD, 0);
    applyStimulus(3'd1, 32'h8000_0000, 32'h8000_0000, 1);
    applyStimulus(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    applyStimulus(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2);
    applyStimulus(3'd4, 32'hFFFF_FFF9, 32'd2, 0);
    applyStimulus(3'd6, 32'hFFFF_FFF9, 32'd2, 0);
    applyStimulus(3'd5, 32'hFFFF_FFFF, 32'd2, 0);
    applyStimulus(3'd4, 32'd5, 32'd0, 0);
    applyStimulus(3'd7, 32'd5, 32'd0, 1);
    applyStimulus(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    applyStimulus(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    applyStimulus(3'd5, 32'd100, 32'd7, 5);

    // Flush a division after ten iteration edges; nothing may come out.
    waitReady();
    i_valid    = 1'b1;
    i_funct3   = 3'd4;
    i_rs1_data = 32'd1000;
    i_rs2_data = 32'd3;
    @(negedge clk);
    i_valid = 1'b0;
    repeat (10) @(negedge clk);
    i_flush = 1'b1;
    @(negedge clk);
    i_flush = 1'b0;
    checkOutput("ready_after_flush", {31'd0, o_ready}, 32'd1);
    checkOutput("busy_after_flush", {31'd0, o_busy}, 32'd0);
    saw_valid = 1'b0;
    repeat (40) begin
      @(negedge clk);
      saw_valid = saw_valid | o_valid;
    end
    checkOutput("no_valid_after_flush", {31'd0, saw_valid}, 32'd0);

    // A flush in IDLE blocks a simultaneous request.
    i_valid    = 1'b1;
    i_flush    = 1'b1;
    i_funct3   = 3'd5;
    i_rs1_data = 32'd9;
    i_rs2_data = 32'd2;
    @(negedge clk);
    i_valid = 1'b0;
    i_flush = 1'b0;
    checkOutput("flush_blocks_accept", {31'd0, o_ready}, 32'd1);
    repeat (3) @(negedge clk);
    checkOutput("flush_blocks_busy", {31'd0, o_busy}, 32'd0);

    // Reset in the middle of a multiply returns every output to reset values.
    applyStimulus(3'd5, 32'd77, 32'd5, 0);
    waitReady();
    i_valid    = 1'b1;
    i_funct3   = 3'd0;
    i_rs1_data = 32'd12345;
    i_rs2_data = 32'd678;
    @(negedge clk);
    i_valid = 1'b0;
    repeat (5) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midop_reset_ready", {31'd0, o_ready}, 32'd1);
    checkOutput("midop_reset_valid", {31'd0, o_valid}, 32'd0);
    checkOutput("midop_reset_busy", {31'd0, o_busy}, 32'd0);
    checkOutput("midop_reset_result", o_result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 40; i++) begin
      f = 3'($urandom_range(0, 7));
      applyStimulus(f, pickOperand(), pickOperand(), int'($urandom_range(0, 3)));
    end

    repeat (5) @(negedge clk);
    checkOutput("scoreboard_drained", 32'(scoreboard.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide execution unit, generalised over DATA_WIDTH.
- Sits in EX beside the ALU. Accepts one operation when the decoder sees OPCODE_R with FUNCT7_R_MULDIV.
- Computes the result over multiple cycles and returns it through a valid/ready handshake.
- The pipeline stalls EX while o_busy is high. Any in-flight operation can be flushed by a redirect.

Parameters:
- DATA_WIDTH, 32, operand/result width; must be even and at least 8.
- CNT_WIDTH, $clog2(DATA_WIDTH)+1, iteration counter width; derived, do not override.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- i_valid  input  1  request valid.
- o_ready  output  1  unit can accept a request.
- i_funct3  input  3  operation select: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- i_rs1_data  input  DATA_WIDTH  operand A (dividend / multiplicand).
- i_rs2_data  input  DATA_WIDTH  operand B (divisor / multiplier).
- i_flush  input  1  abort the current operation.
- o_valid  output  1  result valid.
- i_ready  input  1  consumer accepts the result.
- o_result  output  DATA_WIDTH  result.
- o_busy  output  1  operation accepted and not yet retired.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; o_valid=0; o_result=0; o_busy=0; o_ready=1.
  - Counter and internal registers clear.
  - Reset mid-operation discards that operation.
- FSM states: IDLE, MUL, DIV, DONE.
- IDLE:
  - o_ready=1.
  - A request is accepted on an edge with i_valid&&o_ready.
  - On accept, latch |A|, |B|, sign flags, funct3 and counter=0.
  - MUL* ops go to MUL; DIV* and REM* ops go to DIV.
  - Special cases go straight to DONE.
- Signedness:
  - MULH, DIV, REM: both operands signed.
  - MULHSU: A signed, B unsigned.
  - MUL, MULHU, DIVU, REMU: unsigned magnitude path.
- MUL state:
  - Shift-add, one multiplier bit per cycle, into a 2*DATA_WIDTH accumulator.
  - DATA_WIDTH cycles, then DONE.
  - Sign-correct (two's-complement negate) when the operand signs differ.
  - MUL returns product[DATA_WIDTH-1:0]; MULH/MULHSU/MULHU return product[2*DATA_WIDTH-1:DATA_WIDTH].
- DIV state:
  - Restoring division, one quotient bit per cycle, DATA_WIDTH cycles, then DONE.
  - Quotient sign = sA^sB; remainder sign = sA.
- Latency:
  - Accept on edge 0; o_valid=1 after edge DATA_WIDTH+1.
  - Special cases: o_valid=1 after edge 1.
- Special cases (RISC-V spec, no trap):
  - Divide by zero: DIV/DIVU return all ones; REM/REMU return A.
  - Signed overflow (A=most negative, B=-1): DIV returns A; REM returns 0.
- DONE state:
  - o_valid=1; o_result is stable and held until i_ready=1.
  - On o_valid&&i_ready, go to IDLE next edge with o_valid=0.
  - No new accept in DONE; o_ready=0.
- o_busy=1 in MUL, DIV and DONE.
- i_flush:
  - In any state, next edge goes to IDLE with o_valid=0; the result is dropped.
  - i_flush has priority over i_valid and i_ready in the same cycle.
  - A flush in IDLE with i_valid=1 prevents the accept.
- Invalid i_funct3: not possible (all 8 encodings defined).

Optional Feature:
- Macro: MULDIV_FAST_MUL_EN.
- Defined:
  - MUL* ops use a single-cycle combinational DATA_WIDTH x DATA_WIDTH signed multiply, with operands sign-extended to DATA_WIDTH+1 per funct3.
  - Registered into DONE; o_valid after edge 1.
  - The MUL state is not synthesised. Divide behaviour is unchanged.
- Undefined: iterative multiply as described under Behaviour.

Decomposition:
- Shared package (core_pkg) gains:
  - FUNCT7_R_MULDIV = 7'h01.
  - FUNCT3_MULDIV_MUL=0, MULH=1, MULHSU=2, MULHU=3, DIV=4, DIVU=5, REM=6, REMU=7.
  - typedef enum muldiv_state_e {IDLE, MUL, DIV, DONE}.
- One sub-module: muldiv_divider.
  - Unsigned restoring divide core: start/done, |A|, |B| in; quotient/remainder out.
  - Instantiated once; sign fix-up stays in muldiv_unit.

Test Plan:
- MUL 7 x 0xFFFFFFFD (-3) -> 0xFFFFFFEB; o_valid after edge 33; o_ready=0 during edges 1-33.
- MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 0xFFFFFFFF / 2 -> 0x7FFFFFFF.
- DIV 5/0 -> 0xFFFFFFFF and REMU 5/0 -> 5, both valid after edge 1; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, REM -> 0.
- Backpressure: DIVU 100/7 with i_ready=0 for 5 cycles after o_valid -> o_result stays 14 and o_valid stays 1; IDLE one edge after i_ready=1.
- Flush: i_flush at edge 10 of a DIV -> o_valid never rises, o_ready=1 after edge 11; also reset mid-MUL -> all outputs at reset values immediately.
